// File: rtl/axi_probe_pkg.sv
// Shared definitions for the AXI4-Lite probe memory: response codes,
// responder FSM states and the address-window check.
package axi_probe_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_RESP,
    ST_RD_WAIT,
    ST_RD_RESP
  } probe_state_e;

  // True when a byte offset (address minus window base) falls inside a
  // window of 'depth' 32-bit words. Unsigned wrap makes below-base addresses huge.
  function automatic logic addr_in_range(input logic [31:0] offset,
                                         input int unsigned depth);
    return offset < (depth << 2);
  endfunction

endpackage

// File: rtl/probe_mem_ram.sv
// Single-port synchronous RAM, DEPTH x 32, per-byte write enables,
// one-cycle registered read (read-before-write on the same port).
module probe_mem_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-masked write and registered read of the addressed word.
  // NOTE: the array has no reset; clearing a RAM would force it into flops
  // and its contents are meant to survive a controller reset anyway.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_probe_mem.sv
// AXI4-Lite responder backed by a word RAM. AW, W and AR each have a
// one-deep capture register; a small FSM services one transaction at a time,
// arbitrating reads against writes round-robin, with programmable read wait.
module axi_probe_mem
  import axi_probe_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned RD_WAIT   = 2,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        s_areset,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Capture registers and their full flags
  logic             aw_full, w_full, ar_full;
  logic [31:0]      aw_addr, w_data, ar_addr;
  logic [3:0]       w_strb;

  // Responder state
  probe_state_e     state;
  logic             prefer_wr;
  logic [3:0]       wait_cnt;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_ok;

  // Datapath glue
  logic [31:0]      aw_off, ar_off;
  logic [IDX_W-1:0] aw_idx, ar_idx, ram_addr;
  logic             aw_ok, ar_ok;
  logic             aw_cap, w_cap, ar_cap;
  logic             wr_rdy, rd_rdy, wr_take, rd_take;
  logic             aw_full_nxt, w_full_nxt, ar_full_nxt;
  logic [3:0]       ram_we;
  logic [31:0]      ram_rdata;

  // Sizes are ignored: every access is one strobe-qualified 32-bit beat.
  logic unused_size;
  assign unused_size = ^{s_axi_awsize, s_axi_arsize};

  assign aw_off = aw_addr - ADDR_BASE;
  assign ar_off = ar_addr - ADDR_BASE;
  assign aw_idx = aw_off[IDX_W+1:2];
  assign ar_idx = ar_off[IDX_W+1:2];
  assign aw_ok  = addr_in_range(aw_off, DEPTH);
  assign ar_ok  = addr_in_range(ar_off, DEPTH);

  assign aw_cap = s_axi_awvalid & s_axi_awready;
  assign w_cap  = s_axi_wvalid  & s_axi_wready;
  assign ar_cap = s_axi_arvalid & s_axi_arready;

  // Arbitration in IDLE: the pointer only breaks ties when both are ready.
  assign wr_rdy  = aw_full & w_full;
  assign rd_rdy  = ar_full;
  assign wr_take = (state == ST_IDLE) & wr_rdy & (~rd_rdy | prefer_wr);
  assign rd_take = (state == ST_IDLE) & rd_rdy & ~wr_take;

  // A capture and a release can never coincide: capture needs the flag clear.
  assign aw_full_nxt = aw_cap | (aw_full & ~wr_take);
  assign w_full_nxt  = w_cap  | (w_full  & ~wr_take);
  assign ar_full_nxt = ar_cap | (ar_full & ~rd_take);

  // The RAM port is shared: a write taken now owns it; otherwise it reads the
  // word being fetched (the fresh AR decode on the take cycle, then rd_idx).
  // A write coinciding with reset is dropped.
  assign ram_we   = (wr_take & aw_ok & ~s_areset) ? w_strb : 4'b0000;
  assign ram_addr = wr_take ? aw_idx : ((state == ST_IDLE) ? ar_idx : rd_idx);

  probe_mem_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (w_data),
    .rdata (ram_rdata)
  );

  // Capture payloads of accepted AW, W and AR beats (pure datapath, no reset).
  always_ff @(posedge clk) begin
    if (aw_cap) aw_addr <= s_axi_awaddr;
    if (w_cap) begin
      w_data <= s_axi_wdata;
      w_strb <= s_axi_wstrb;
    end
    if (ar_cap) ar_addr <= s_axi_araddr;
  end

  // Full flags with readys registered as their complement.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (s_areset) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      ar_full       <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
    end else begin
      aw_full       <= aw_full_nxt;
      w_full        <= w_full_nxt;
      ar_full       <= ar_full_nxt;
      s_axi_awready <= ~aw_full_nxt;
      s_axi_wready  <= ~w_full_nxt;
      s_axi_arready <= ~ar_full_nxt;
    end
  end

  // Responder FSM with registered B and R channel outputs.
  always_ff @(posedge clk) begin
    if (s_areset) begin
      state        <= ST_IDLE;
      prefer_wr    <= 1'b1;
      wait_cnt     <= 4'd0;
      rd_idx       <= '0;
      rd_ok        <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_rdata  <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Loser of a contested decision wins the next contest.
          if (wr_rdy && rd_rdy) prefer_wr <= ~prefer_wr;
          if (wr_take) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
            state        <= ST_WR_RESP;
          end else if (rd_take) begin
            rd_idx   <= ar_idx;
            rd_ok    <= ar_ok;
            wait_cnt <= 4'(RD_WAIT);
            state    <= (RD_WAIT == 0) ? ST_RD_RESP : ST_RD_WAIT;
          end
        end
        ST_WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          // Leave as the counter reaches zero; RD_RESP adds the RAM cycle.
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= ST_RD_RESP;
        end
        ST_RD_RESP: begin
          if (!s_axi_rvalid) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_ok ? ram_rdata : 32'h0;
            s_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
